// File: rtl/ddr_wr_burst_arb.sv
// Round-robin arbiter sharing one DDR write-burst master port among NUM_REQ burst writers.
// Latency: m_wr_burst_req rises 1 cycle after an eligible request; data/strobe routing is combinational.
// Backpressure: a granted burst runs until the controller finishes it; other requesters wait in IDLE arbitration.
module ddr_wr_burst_arb #(
  parameter int          NUM_REQ     = 4,
  parameter int          ID_WD       = $clog2(NUM_REQ),
  parameter int          DDR_ADDR_WD = 32,
  parameter int          DDR_DATA_WD = 512,
  parameter logic [15:0] WDOG_CYC    = 16'd20000
) (
  input  logic                           ddr_clk,
  input  logic                           ddr_rst_n,
  input  logic                           cfg_rst,
  input  logic [NUM_REQ-1:0]             i_req_mask,
  input  logic [NUM_REQ-1:0]             s_wr_burst_req,
  input  logic [NUM_REQ*10-1:0]          s_wr_burst_len,
  input  logic [NUM_REQ*DDR_ADDR_WD-1:0] s_wr_burst_addr,
  output logic [NUM_REQ-1:0]             s_wr_burst_data_req,
  input  logic [NUM_REQ*DDR_DATA_WD-1:0] s_wr_burst_data,
  output logic [NUM_REQ-1:0]             s_wr_burst_finish,
  output logic                           m_wr_burst_req,
  output logic [9:0]                     m_wr_burst_len,
  output logic [DDR_ADDR_WD-1:0]         m_wr_burst_addr,
  input  logic                           m_wr_burst_data_req,
  output logic [DDR_DATA_WD-1:0]         m_wr_burst_data,
  input  logic                           m_wr_burst_finish,
  output logic                           o_busy,
  output logic [ID_WD-1:0]               o_grant_id,
  output logic                           o_wdog_err,
  output logic [31:0]                    o_burst_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     grant_load;
  logic                     burst_done;
  logic [NUM_REQ-1:0]       eligible;
  logic                     win_vld;
  logic [ID_WD-1:0]         win_id;
  logic [ID_WD-1:0]         scan_id;
  logic [9:0]               win_len;
  logic [DDR_ADDR_WD-1:0]   win_addr;
  logic [ID_WD-1:0]         last_ptr;
  logic [15:0]              wdog_cnt;
  logic                     wdog_run;
  logic                     wdog_hit;

  assign eligible = s_wr_burst_req & ~i_req_mask;

  // Circular search starting just after the last grant; scanning from the far
  // end backwards lets the nearest eligible index overwrite earlier candidates.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan_id = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      scan_id = ID_WD'((int'(last_ptr) + off) % NUM_REQ);
      if (eligible[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  // Select the winner's length and address for latching at grant time.
  always_comb begin
    win_len  = '0;
    win_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_WD'(k)) begin
        win_len  = s_wr_burst_len[k*10 +: 10];
        win_addr = s_wr_burst_addr[k*DDR_ADDR_WD +: DDR_ADDR_WD];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; a finish seen while still in REQ closes the burst directly.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    burst_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          grant_load = 1'b1;
          state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_wr_burst_finish) begin
          state_nxt = ST_DONE;
        end else if (m_wr_burst_data_req) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_wr_burst_finish) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        burst_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping: latch winner parameters and hold them for the whole burst.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      m_wr_burst_req  <= 1'b0;
      m_wr_burst_len  <= '0;
      m_wr_burst_addr <= '0;
      o_grant_id      <= '0;
      o_busy          <= 1'b0;
      last_ptr        <= ID_WD'(NUM_REQ - 1);
    end else begin
      m_wr_burst_req <= (state_nxt == ST_REQ);
      if (grant_load) begin
        m_wr_burst_len  <= win_len;
        m_wr_burst_addr <= win_addr;
        o_grant_id      <= win_id;
        o_busy          <= 1'b1;
      end else if (burst_done) begin
        o_busy   <= 1'b0;
        last_ptr <= o_grant_id;
      end
    end
  end

  assign wdog_run = (state == ST_REQ) || (state == ST_DATA);
  assign wdog_hit = wdog_run && (wdog_cnt == (WDOG_CYC - 16'd1));

  // Burst watchdog; the counter saturates so a hung burst cannot wrap it.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      wdog_cnt <= '0;
    end else if (!wdog_run) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WDOG_CYC) begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end
  end

  // Status: sticky watchdog flag and completed-burst counter; cfg_rst has priority.
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      o_wdog_err  <= 1'b0;
      o_burst_cnt <= '0;
    end else if (cfg_rst) begin
      o_wdog_err  <= 1'b0;
      o_burst_cnt <= '0;
    end else begin
      if (wdog_hit) begin
        o_wdog_err <= 1'b1;
      end
      if (burst_done) begin
        o_burst_cnt <= o_burst_cnt + 32'd1;
      end
    end
  end

  // Route controller strobes only to the granted requester, and only while busy.
  always_comb begin
    s_wr_burst_data_req = '0;
    s_wr_burst_finish   = '0;
    if (o_busy) begin
      s_wr_burst_data_req[o_grant_id] = m_wr_burst_data_req;
      s_wr_burst_finish[o_grant_id]   = m_wr_burst_finish;
    end
  end

  // Write data follows the granted requester's FWFT output in the same cycle.
  always_comb begin
    m_wr_burst_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant_id == ID_WD'(k)) begin
        m_wr_burst_data = s_wr_burst_data[k*DDR_DATA_WD +: DDR_DATA_WD];
      end
    end
  end

endmodule
